// File: rtl/sync_timing_pkg.sv
// Shared timing definitions: step interpretation modes and the standard
// 640x480 region lengths, used by the sync axis timer and its users.
package sync_timing_pkg;

  // How the step input of an axis timer is interpreted
  localparam int STEP_LEVEL = 0;  // every clock with step high advances
  localparam int STEP_RISE  = 1;  // advance once per rising edge of step
  localparam int STEP_FALL  = 2;  // advance once per falling edge of step

  // 640x480 horizontal axis, in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;

  // 640x480 vertical axis, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  // Length of one full period for a set of region lengths
  function automatic int period_len(input int act, input int front,
                                    input int sync, input int back);
    return act + front + sync + back;
  endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Turns the raw step request into a one-clock advance strobe according to
// STEP_MODE (level, rising edge or falling edge of step).
module step_edge_detect
  import sync_timing_pkg::*;
#(
  parameter int STEP_MODE = STEP_FALL
) (
  input  logic clock,
  input  logic reset,
  input  logic step,
  output logic adv
);

  logic step_q;

  // step delayed by one clock, cleared by reset so no edge is seen on release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // select the advance strobe for the configured mode
  always_comb begin
    adv = step;
    case (STEP_MODE)
      STEP_RISE: adv = step & ~step_q;
      STEP_FALL: adv = ~step & step_q;
      default:   adv = step;
    endcase
  end

endmodule

// File: rtl/sync_axis_timer.sv
// One axis of a raster timing generator: counts steps through the
// active / front porch / sync / back porch regions and wraps.
// Optional feature macro: SYNC_AXIS_SHADOW_EN -- region lengths are sampled
// into shadow registers at reset release and at every period end, so input
// changes only take effect at the start of the next period.
module sync_axis_timer
  import sync_timing_pkg::*;
#(
  parameter int WIDTH            = 10,
  parameter int STEP_MODE        = STEP_FALL,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] active_len,
  input  logic [WIDTH-1:0] front_len,
  input  logic [WIDTH-1:0] sync_len,
  input  logic [WIDTH-1:0] back_len,
  input  logic             step,
  output logic [WIDTH-1:0] position,
  output logic             sync,
  output logic             active,
  output logic             period_end
);

  // Sums of up to four WIDTH-bit lengths need two extra bits
  localparam int TW = WIDTH + 2;

  logic             adv;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] act_e, front_e, sync_e, back_e;
  logic [TW-1:0]    total, count_x, sync_start, sync_stop;
  logic             at_last, in_sync;

  step_edge_detect #(
    .STEP_MODE (STEP_MODE)
  ) u_step (
    .clock (clock),
    .reset (reset),
    .step  (step),
    .adv   (adv)
  );

`ifdef SYNC_AXIS_SHADOW_EN
  logic [WIDTH-1:0] act_s, front_s, sync_s, back_s;
  logic             loaded;

  // capture lengths on the first clock after reset and at every wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_s   <= '0;
      front_s <= '0;
      sync_s  <= '0;
      back_s  <= '0;
      loaded  <= 1'b0;
    end else if (!loaded || period_end) begin
      act_s   <= active_len;
      front_s <= front_len;
      sync_s  <= sync_len;
      back_s  <= back_len;
      loaded  <= 1'b1;
    end
  end

  // until the first capture the live inputs describe the period in progress
  always_comb begin
    act_e   = loaded ? act_s   : active_len;
    front_e = loaded ? front_s : front_len;
    sync_e  = loaded ? sync_s  : sync_len;
    back_e  = loaded ? back_s  : back_len;
  end
`else
  assign act_e   = active_len;
  assign front_e = front_len;
  assign sync_e  = sync_len;
  assign back_e  = back_len;
`endif

  assign total      = TW'(act_e) + TW'(front_e) + TW'(sync_e) + TW'(back_e);
  assign count_x    = TW'(count);
  assign sync_start = TW'(act_e) + TW'(front_e);
  assign sync_stop  = sync_start + TW'(sync_e);

  // >= rather than == so a live shrink below the current count still wraps
  assign at_last = (total != '0) && (count_x >= total - TW'(1));

  // step position counter; an empty period pins it at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (total == '0) begin
      count <= '0;
    end else if (adv) begin
      count <= at_last ? '0 : count + WIDTH'(1);
    end
  end

  // strobes are held off while reset is low so a partial period never ends
  assign period_end = adv & at_last & reset;
  assign in_sync    = reset && (count_x >= sync_start) && (count_x < sync_stop);

  assign position = count;
  assign active   = (count < act_e);
  assign sync     = SYNC_ACTIVE_HIGH ? in_sync : ~in_sync;

endmodule
